// File: rtl/led_pkg.sv
// Shared state encoding and default sizing for the LED sequencer.
package led_pkg;

  localparam int CNT_W_DEFAULT    = 3;
  localparam int TICK_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2,
    PAUSE    = 2'd3
  } led_state_t;

  function automatic logic is_run(input led_state_t s);
    return (s == RUN_UP) || (s == RUN_DOWN);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal cycle.
module led_tick_gen import led_pkg::*; #(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] cnt;

  // Terminal-count flag; the sequencer registers the visible tick itself.
  assign tick = en && !clr && (cnt == LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED counter sequencer: start/stop/pause FSM driving a prescaled up/down
// counter with wrap or bounce behaviour at the ends.
module led_sequencer import led_pkg::*; #(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             bounce,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] led_count,
  output logic             busy,
  output logic             tick,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  led_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_d;
  logic             dir_q, dir_d;   // direction to resume from PAUSE, 1 = down
  logic             tick_d, wrap_d;
  logic             pre_en, pre_clr, step;

  // Prescaler control kept apart from the main decode so step never loops back.
  assign pre_clr = load || ((state_q == IDLE) && start && !stop);
  assign pre_en  = is_run(state_q) && !stop && !load;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (step)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    count_d = led_count;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    if (load) begin
      count_d = load_val;
    end else if (stop) begin
      case (state_q)
        RUN_UP: begin
          state_d = PAUSE;
          dir_d   = 1'b0;
        end
        RUN_DOWN: begin
          state_d = PAUSE;
          dir_d   = 1'b1;
        end
        PAUSE:   state_d = IDLE;
        default: ;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = dir ? RUN_DOWN : RUN_UP;
        end
        PAUSE: begin
          if (start) state_d = dir_q ? RUN_DOWN : RUN_UP;
        end
        RUN_UP: begin
          if (step) begin
            tick_d = 1'b1;
            if (led_count == CNT_MAX) begin
              wrap_d = 1'b1;
              if (bounce) begin
                count_d = CNT_MAX - ONE;
                state_d = RUN_DOWN;
              end else begin
                count_d = '0;
              end
            end else begin
              count_d = led_count + ONE;
            end
          end
        end
        RUN_DOWN: begin
          if (step) begin
            tick_d = 1'b1;
            if (led_count == '0) begin
              wrap_d = 1'b1;
              if (bounce) begin
                count_d = ONE;
                state_d = RUN_UP;
              end else begin
                count_d = CNT_MAX;
              end
            end else begin
              count_d = led_count - ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      led_count <= '0;
      dir_q     <= 1'b0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_count <= count_d;
      dir_q     <= dir_d;
      busy      <= is_run(state_d);
      tick      <= tick_d;
      wrap      <= wrap_d;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer (TICK_DIV=4, CNT_W=3): stimulus queues
// the expected tick edge/count/wrap, a negedge monitor pops and compares.
module tb_led_sequencer;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             dir = 1'b0;
  logic             bounce = 1'b0;
  logic             load = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic [CNT_W-1:0] led_count;
  logic             busy, tick, wrap;

  typedef struct {
    int cyc;
    int count;
    int wrap;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  int seq2_cnt[15]  = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int seq2_wrap[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

  led_sequencer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .bounce    (bounce),
    .load      (load),
    .load_val  (load_val),
    .led_count (led_count),
    .busy      (busy),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_tick(input int edge_no, input int count, input int w);
    exp_t e;
    e.cyc   = edge_no;
    e.count = count;
    e.wrap  = w;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
    cycles(2);
    reset = 1'b0;
    check("reset_count", led_count, 0);
    check("reset_busy", busy, 0);
    check("reset_tick", tick, 0);
    check("reset_wrap", wrap, 0);
  endtask

  // Monitor: every tick must match the head of the scoreboard; a head whose
  // edge has passed without a tick is reported as missed.
  always @(negedge clk) begin
    if (tick) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_count", led_count, e.count);
        check("tick_wrap", wrap, e.wrap);
      end
    end else begin
      if (wrap) check("wrap_without_tick", 1, 0);
      if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        check("missed_tick", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int e0, r, r2, i;

    // Up count with wrap at 7->0.
    apply_reset();
    dir = 1'b0; bounce = 1'b0; start = 1'b1;
    e0 = cyc + 1;
    for (int k = 1; k <= 8; k++) expect_tick(e0 + 4 * k, k % 8, (k == 8) ? 1 : 0);
    cycles(1); start = 1'b0;
    cycles(33);
    check("up_final_count", led_count, 0);
    check("up_busy", busy, 1);
    check("up_sb_empty", sb.size(), 0);

    // Bounce from 0 upward: reflect at 7 and at 0.
    apply_reset();
    dir = 1'b0; bounce = 1'b1; start = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 15; k++) expect_tick(e0 + 4 * (k + 1), seq2_cnt[k], seq2_wrap[k]);
    cycles(1); start = 1'b0;
    cycles(30);
    check("bounce_busy_mid", busy, 1);
    cycles(31);
    check("bounce_busy_end", busy, 1);
    check("bounce_final_count", led_count, 1);
    check("bounce_sb_empty", sb.size(), 0);
    bounce = 1'b0;

    // Pause mid-phase, resume at held phase, stop in tick cycle, stop twice.
    apply_reset();
    dir = 1'b0; start = 1'b1;
    e0 = cyc + 1;
    expect_tick(e0 + 4, 1, 0);
    expect_tick(e0 + 8, 2, 0);
    cycles(1); start = 1'b0;
    cycles(9);
    stop = 1'b1;
    cycles(1); stop = 1'b0;
    cycles(10);
    check("pause_count", led_count, 2);
    check("pause_busy", busy, 0);
    r = cyc + 1;
    start = 1'b1;
    expect_tick(r + 3, 3, 0);
    cycles(1); start = 1'b0;
    check("resume_busy", busy, 1);
    cycles(6);
    stop = 1'b1;
    cycles(1); stop = 1'b0;
    check("stop_in_tick_count", led_count, 3);
    check("stop_in_tick_tick", tick, 0);
    cycles(2);
    start = 1'b1;
    r2 = cyc + 1;
    expect_tick(r2 + 1, 4, 0);
    cycles(1); start = 1'b0;
    cycles(1);
    stop = 1'b1;
    cycles(2); stop = 1'b0;
    cycles(1);
    check("idle_busy", busy, 0);
    check("idle_count", led_count, 4);
    dir = 1'b1; start = 1'b1;
    i = cyc + 1;
    expect_tick(i + 4, 3, 0);
    expect_tick(i + 8, 2, 0);
    cycles(1); start = 1'b0; dir = 1'b0;

    // Load during RUN_DOWN restarts the prescale phase.
    cycles(9);
    load = 1'b1; load_val = 3'd5;
    cycles(1); load = 1'b0;
    check("load_count", led_count, 5);
    check("load_no_tick", tick, 0);
    expect_tick(i + 14, 4, 0);
    expect_tick(i + 18, 3, 0);
    cycles(9);
    check("load_busy", busy, 1);
    check("load_sb_empty", sb.size(), 0);

    // start+stop together in IDLE, then reset mid-run overriding a load.
    apply_reset();
    start = 1'b1; stop = 1'b1;
    cycles(1); start = 1'b0; stop = 1'b0;
    cycles(6);
    check("startstop_busy", busy, 0);
    check("startstop_count", led_count, 0);
    dir = 1'b0; start = 1'b1;
    e0 = cyc + 1;
    for (int k = 1; k <= 6; k++) expect_tick(e0 + 4 * k, k, 0);
    cycles(1); start = 1'b0;
    cycles(24);
    check("prereset_count", led_count, 6);
    reset = 1'b1; load = 1'b1; load_val = 3'd5;
    cycles(1); reset = 1'b0; load = 1'b0;
    check("midrun_reset_count", led_count, 0);
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_tick", tick, 0);
    check("midrun_reset_wrap", wrap, 0);
    cycles(8);
    check("final_busy", busy, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
